// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The loader depth and the instruction memory depth both come from IMEM_WORDS.
package imem_pkg;

   localparam int IMEM_WORDS     = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
      DONE,
      ERR
   } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8->32 assembler: one byte per accept strobe, word_valid on the 4th.
// word is presented combinationally on that same cycle so the caller can register it directly.
module byte_packer
   import imem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam int IW = $clog2(BYTES_PER_WORD);

   logic [IW-1:0] idx;
   logic [31:0]   partial;

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         partial <= '0;
      end else if (clear) begin
         idx     <= '0;
         partial <= '0;
      end else if (accept) begin
         partial[{idx, 3'b000} +: 8] <= data;
         idx                         <= idx + IW'(1);
      end
   end

   assign word_valid = accept && (idx == IW'(BYTES_PER_WORD - 1));
   assign word       = {data, partial[23:0]};

endmodule

// File: rtl/imem_loader.sv
// Byte-stream image loader: header word N, then N little-endian words written to imem.
// The core is held in reset until the whole image has been accepted.
module imem_loader
   import imem_pkg::*;
#(
   parameter  int MEM_SIZE = IMEM_WORDS,
   localparam int CW       = $clog2(MEM_SIZE + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   output logic          rx_ready,
   output logic          WE,
   output logic [31:0]   WA,
   output logic [31:0]   WD,
   output logic          cpu_hold,
   output logic          done,
   output logic          error,
   output logic [CW-1:0] words_loaded
);

   loader_state_t state, next_state;

   logic          accept;
   logic [31:0]   word;
   logic          word_valid;
   logic [CW-1:0] n_words;
   logic [CW-1:0] wl_inc;
   logic          hdr_bad;
   logic          last_word;
   logic          restart;

   assign rx_ready  = (state == HDR) || (state == DATA);
   assign accept    = rx_valid && rx_ready;
   assign hdr_bad   = (word == 32'd0) || (word > 32'(MEM_SIZE));
   assign wl_inc    = words_loaded + CW'(1);
   assign last_word = (wl_inc == n_words);
   // start is only honoured between loads; HDR/DATA ignore it.
   assign restart   = start && (state inside {IDLE, DONE, ERR});

   // Packer is held clear outside HDR/DATA so every load starts at byte 0.
   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (!rx_ready),
      .accept     (accept),
      .data       (rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      case (state)
         IDLE:       if (start) next_state = HDR;
         HDR:        if (word_valid) next_state = hdr_bad ? ERR : DATA;
         DATA:       if (word_valid && last_word) next_state = DONE;
         DONE, ERR:  if (start) next_state = HDR;
         default:    next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         WE           <= 1'b0;
         WA           <= '0;
         WD           <= '0;
         cpu_hold     <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
         n_words      <= '0;
      end else begin
         WE       <= (state == DATA) && word_valid;
         done     <= (next_state == DONE);
         error    <= (next_state == ERR);
         cpu_hold <= (next_state != DONE);

         if (state == HDR && word_valid)
            n_words <= CW'(word);

         if (restart)
            words_loaded <= '0;
         else if (state == DATA && word_valid) begin
            WA           <= 32'({words_loaded, 2'b00});
            WD           <= word;
            words_loaded <= wl_inc;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, header errors, stalls, back-to-back, reset and restart.
module tb_imem_loader;
   import imem_pkg::*;

   localparam int MEM_SIZE = IMEM_WORDS;
   localparam int CW       = $clog2(MEM_SIZE + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_ready, WE, cpu_hold, done, error;
   logic [31:0]   WA, WD;
   logic [CW-1:0] words_loaded;

   imem_loader #(.MEM_SIZE(MEM_SIZE)) dut (
      .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .WE(WE), .WA(WA), .WD(WD), .cpu_hold(cpu_hold),
      .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] wa;
      logic [31:0] wd;
      int          c;
      logic        dn;
   } wr_t;

   wr_t log_q[$];

   always @(posedge clk) cyc++;
   always @(negedge clk) if (WE === 1'b1) log_q.push_back('{WA, WD, cyc, done});

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // All driving tasks start and end at posedge+1.
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic pulse_start(input bit with_byte);
      start = 1'b1;
      if (with_byte) begin
         rx_valid = 1'b1;
         rx_data  = 8'hAA;
         #1 check("start_cycle_no_ready", rx_ready, 1'b0);
      end
      @(posedge clk);
      #1 start = 1'b0;
      rx_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      while (!rx_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready) check("rx_ready_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8]);
         repeat (gap) @(posedge clk);
         if (gap > 0) #1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_entry(input string tag, input int k, input logic [31:0] wa, input logic [31:0] wd);
      if (k < log_q.size()) begin
         check({tag, "_wa"}, log_q[k].wa, wa);
         check({tag, "_wd"}, log_q[k].wd, wd);
      end else
         check({tag, "_missing"}, 32'(log_q.size()), 32'(k + 1));
   endtask

   initial begin
      int bad;

      // Reset state
      do_reset();
      check("rst_rx_ready", rx_ready, 1'b0);
      check("rst_we", WE, 1'b0);
      check("rst_wa", WA, 32'h0);
      check("rst_wd", WD, 32'h0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_words", 32'(words_loaded), 32'd0);
      check("rst_cpu_hold", cpu_hold, 1'b1);

      // Nominal 2-word image
      log_q.delete();
      pulse_start(1'b0);
      check("hdr_rx_ready", rx_ready, 1'b1);
      send_word(32'd2, 0);
      send_word(32'h00100513, 0);
      check("nom_mid_words", 32'(words_loaded), 32'd1);
      send_word(32'h00200593, 0);
      check("nom_last_we", WE, 1'b1);
      check("nom_last_done", done, 1'b1);
      check("nom_cpu_hold", cpu_hold, 1'b0);
      idle(1);
      check("nom_we_pulse", WE, 1'b0);
      check("nom_wa_hold", WA, 32'h4);
      check("nom_count", 32'(log_q.size()), 32'd2);
      check_entry("nom0", 0, 32'h0, 32'h00100513);
      check_entry("nom1", 1, 32'h4, 32'h00200593);
      check("nom_words", 32'(words_loaded), 32'd2);
      check("nom_rx_ready", rx_ready, 1'b0);

      // Restart from DONE, then start in DATA is ignored
      log_q.delete();
      pulse_start(1'b0);
      check("rs_cpu_hold", cpu_hold, 1'b1);
      check("rs_done", done, 1'b0);
      check("rs_words", 32'(words_loaded), 32'd0);
      send_word(32'd2, 0);
      send_word(32'h11111111, 0);
      start = 1'b1;
      idle(1);
      start = 1'b0;
      check("data_start_words", 32'(words_loaded), 32'd1);
      check("data_start_ready", rx_ready, 1'b1);
      send_word(32'h22222222, 0);
      idle(1);
      check("data_start_count", 32'(log_q.size()), 32'd2);
      check_entry("ds1", 1, 32'h4, 32'h22222222);
      check("data_start_done", done, 1'b1);
      check("data_start_wl", 32'(words_loaded), 32'd2);

      // Header larger than MEM_SIZE, then recovery with a byte offered on the start cycle
      log_q.delete();
      pulse_start(1'b0);
      send_word(32'h21, 0);
      idle(1);
      check("big_error", error, 1'b1);
      check("big_cpu_hold", cpu_hold, 1'b1);
      check("big_rx_ready", rx_ready, 1'b0);
      check("big_done", done, 1'b0);
      check("big_no_we", 32'(log_q.size()), 32'd0);
      pulse_start(1'b1);
      check("rec_error_clr", error, 1'b0);
      send_word(32'd1, 0);
      send_word(32'hDEADBEEF, 0);
      idle(1);
      check("rec_done", done, 1'b1);
      check("rec_count", 32'(log_q.size()), 32'd1);
      check_entry("rec0", 0, 32'h0, 32'hDEADBEEF);

      // Zero header
      pulse_start(1'b0);
      send_word(32'd0, 0);
      check("zero_error", error, 1'b1);
      check("zero_cpu_hold", cpu_hold, 1'b1);

      // MEM_SIZE-sized image is legal; bytes back-to-back
      log_q.delete();
      pulse_start(1'b0);
      send_word(32'd32, 0);
      for (int k = 0; k < 32; k++) send_word(32'hA5000000 + 32'(k), 0);
      idle(2);
      check("b2b_count", 32'(log_q.size()), 32'd32);
      bad = 0;
      for (int k = 0; k < log_q.size(); k++) begin
         if (log_q[k].wa !== 32'(k * 4) || log_q[k].wd !== 32'hA5000000 + 32'(k)) bad++;
         if (k > 0 && log_q[k].c - log_q[k-1].c != 4) bad++;
      end
      check("b2b_seq_errors", 32'(bad), 32'd0);
      if (log_q.size() == 32) begin
         check("b2b_last_wa", log_q[31].wa, 32'h7C);
         check("b2b_done_on_last", log_q[31].dn, 1'b1);
         check("b2b_not_done_early", log_q[30].dn, 1'b0);
      end
      check("b2b_words", 32'(words_loaded), 32'd32);

      // Stalls between every byte
      do_reset();
      log_q.delete();
      pulse_start(1'b0);
      send_word(32'd2, 3);
      send_word(32'h00100513, 3);
      send_word(32'h00200593, 3);
      idle(4);
      check("stall_count", 32'(log_q.size()), 32'd2);
      check_entry("stall0", 0, 32'h0, 32'h00100513);
      check_entry("stall1", 1, 32'h4, 32'h00200593);
      check("stall_done", done, 1'b1);

      // Reset in the middle of word 1 of a 3-word image
      log_q.delete();
      pulse_start(1'b0);
      send_word(32'd3, 0);
      send_word(32'hCAFE0001, 0);
      send_byte(8'h02);
      send_byte(8'h00);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_we", WE, 1'b0);
      check("mid_rst_hold", cpu_hold, 1'b1);
      check("mid_rst_ready", rx_ready, 1'b0);
      check("mid_rst_words", 32'(words_loaded), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      check("mid_rst_count", 32'(log_q.size()), 32'd1);
      log_q.delete();
      pulse_start(1'b0);
      send_word(32'd3, 0);
      send_word(32'hCAFE0001, 0);
      send_word(32'hCAFE0002, 0);
      send_word(32'hCAFE0003, 0);
      idle(1);
      check("reload_count", 32'(log_q.size()), 32'd3);
      check_entry("reload2", 2, 32'h8, 32'hCAFE0003);
      check("reload_words", 32'(words_loaded), 32'd3);
      check("reload_done", done, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
